alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_fifo_mem.sv | 28 ++
 rtl/alu_result_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and the FIFO entry layout
// used by the result FIFO and its storage.
package alu_pkg;

  localparam int OP_W     = 3;
  localparam int RESULT_W = 32;
  localparam int FLAGS_W  = 4;
  localparam int ENTRY_W  = OP_W + RESULT_W + FLAGS_W;

  localparam logic [OP_W-1:0] OP_NOTA = 3'b000;
  localparam logic [OP_W-1:0] OP_NOTB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b110;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b111;

  // Flag vector is {c,n,z,v}
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [RESULT_W-1:0] result;
    logic [FLAGS_W-1:0]  flags;
  } alu_entry_t;

  // Only arithmetic ops produce meaningful carry/overflow flags.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// Result storage: DEPTH x ENTRY_W array with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module alu_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Write port: store the accepted entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Buffers ALU results (op, result, flags) in FIFO order and accumulates
// sticky carry/overflow status from arithmetic pushes.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [RESULT_W-1:0]      in_result,
  input  logic [FLAGS_W-1:0]       in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [RESULT_W-1:0]      out_result,
  output logic [FLAGS_W-1:0]       out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     sticky_c,
  output logic                     sticky_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          sticky_c_r;
  logic          sticky_v_r;

  logic          in_ready_s;
  logic          out_valid_s;
  logic          push_s;
  logic          pop_s;
  logic          set_c_s;
  logic          set_v_s;
  alu_entry_t    wr_entry_s;
  alu_entry_t    head_s;
  logic [ENTRY_W-1:0] rd_data_s;

  // Ready depends on registered occupancy only, so a full FIFO never
  // accepts a push even when a pop happens in the same cycle.
  assign in_ready_s  = (count_r < CW'(DEPTH));
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready;

  assign wr_entry_s  = {in_op, in_result, in_flags};
  assign head_s      = rd_data_s;

  assign set_c_s = push_s && is_arith(in_op) && in_flags[FLAG_C];
  assign set_v_s = push_s && is_arith(in_op) && in_flags[FLAG_V];

  alu_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky status: a setting push in the same cycle wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_c_r <= 1'b0;
      sticky_v_r <= 1'b0;
    end else begin
      if (set_c_s) begin
        sticky_c_r <= 1'b1;
      end else if (clr_sticky) begin
        sticky_c_r <= 1'b0;
      end
      if (set_v_s) begin
        sticky_v_r <= 1'b1;
      end else if (clr_sticky) begin
        sticky_v_r <= 1'b0;
      end
    end
  end

  // Head fields are zeroed when empty so stale storage never leaks out.
  always_comb begin
    out_op     = {OP_W{1'b0}};
    out_result = {RESULT_W{1'b0}};
    out_flags  = {FLAGS_W{1'b0}};
    if (out_valid_s) begin
      out_op     = head_s.op;
      out_result = head_s.result;
      out_flags  = head_s.flags;
    end else begin
      out_op     = {OP_W{1'b0}};
      out_result = {RESULT_W{1'b0}};
      out_flags  = {FLAGS_W{1'b0}};
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign count     = count_r;
  assign sticky_c  = sticky_c_r;
  assign sticky_v  = sticky_v_r;

endmodule
